// File: rtl/gpio_ctrl_ip_if.sv
// Single-cycle peripheral bus: combinational read data, write on clock edge.
interface gpio_ctrl_ip_if;
    logic        valid;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output valid, output we, output addr, output wdata, input rdata);
    modport slave  (input valid, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/gpio_ctrl_ip.sv
// GPIO controller: direction/data registers with set/clear/toggle aliases,
// synchronised and optionally debounced inputs, edge-triggered sticky interrupts.
module gpio_ctrl_ip #(
    parameter int N_GPIO      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DB_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    gpio_ctrl_ip_if.slave     bus,
    input  logic [N_GPIO-1:0] gpio_in,
    output logic [N_GPIO-1:0] gpio_out,
    output logic [N_GPIO-1:0] gpio_oe,
    output logic              irq
);
    localparam logic [7:0] A_DATA = 8'h00, A_DIR  = 8'h04, A_READ = 8'h08,
                           A_SET  = 8'h0C, A_CLR  = 8'h10, A_TGL  = 8'h14,
                           A_RISE = 8'h18, A_FALL = 8'h1C, A_STAT = 8'h20,
                           A_DEB  = 8'h24;

    logic [N_GPIO-1:0] data, dir, rise_en, fall_en, status;
    logic [DB_W-1:0]   deb_cfg, cnt;
    logic [SYNC_STAGES-1:0][N_GPIO-1:0] sync_q;
    logic [N_GPIO-1:0] sync, smp, filt_q, filt, filt_d, rise, fall, eq, w1c, wd;
    logic [7:0]        a;
    logic              wr, bypass, tick, cfg_wr;
    logic [31:0]       rdata;
    logic              unused_bits;

    assign a      = bus.addr[7:0];
    assign wd     = bus.wdata[N_GPIO-1:0];
    assign wr     = bus.valid && bus.we;
    assign cfg_wr = wr && (a == A_DEB);
    assign w1c    = (wr && a == A_STAT) ? wd : '0;
    assign unused_bits = ^{bus.addr[31:8], bus.wdata};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data    <= '0;
            dir     <= '0;
            rise_en <= '0;
            fall_en <= '0;
            deb_cfg <= '0;
        end else if (wr) begin
            case (a)
                A_DATA: data    <= wd;
                A_DIR:  dir     <= wd;
                A_SET:  data    <= data | wd;
                A_CLR:  data    <= data & ~wd;
                A_TGL:  data    <= data ^ wd;
                A_RISE: rise_en <= wd;
                A_FALL: fall_en <= wd;
                A_DEB:  deb_cfg <= bus.wdata[DB_W-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int s = 1; s < SYNC_STAGES; s++)
                sync_q[s] <= sync_q[s-1];
        end
    end
    assign sync = sync_q[SYNC_STAGES-1];

    // Shared prescaler: holds D for one cycle (the tick) then wraps to 0.
    assign bypass = (deb_cfg == '0);
    assign tick   = !bypass && (cnt == deb_cfg);

    always_ff @(posedge clk) begin
        if (!rst_n || cfg_wr || bypass || tick)
            cnt <= '0;
        else
            cnt <= cnt + DB_W'(1);
    end

    // filt_q follows sync while bypassed so enabling the filter starts from the live level.
    assign eq = ~(sync ^ smp);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            smp    <= '0;
            filt_q <= '0;
        end else if (bypass) begin
            filt_q <= sync;
        end else if (tick) begin
            smp    <= sync;
            filt_q <= (sync & eq) | (filt_q & ~eq);
        end
    end
    assign filt = bypass ? sync : filt_q;

    assign rise = filt & ~filt_d;
    assign fall = ~filt & filt_d;

    // A fresh edge is OR'd in after the W1C mask, so it survives a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_d <= '0;
            status <= '0;
        end else begin
            filt_d <= filt;
            status <= (status & ~w1c) | (rise & rise_en) | (fall & fall_en);
        end
    end

    always_comb begin
        rdata = '0;
        case (a)
            A_DATA: rdata[N_GPIO-1:0] = data;
            A_DIR:  rdata[N_GPIO-1:0] = dir;
            A_READ: rdata[N_GPIO-1:0] = (dir & data) | (~dir & filt);
            A_RISE: rdata[N_GPIO-1:0] = rise_en;
            A_FALL: rdata[N_GPIO-1:0] = fall_en;
            A_STAT: rdata[N_GPIO-1:0] = status;
            A_DEB:  rdata[DB_W-1:0]   = deb_cfg;
            default: ;
        endcase
    end
    assign bus.rdata = rdata;

    assign gpio_out = data & dir;
    assign gpio_oe  = dir;
    assign irq      = |status;
endmodule

// File: tb/tb_gpio_ctrl_ip.sv
// Directed bench for gpio_ctrl_ip with 16 pins, 2-stage sync, 16-bit debounce.
module tb_gpio_ctrl_ip;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] gpio_in, gpio_out, gpio_oe;
    logic         irq;
    int           checks = 0;
    int           errors = 0;
    int           n;
    logic         seen;

    gpio_ctrl_ip_if bus ();

    gpio_ctrl_ip #(.N_GPIO(N), .SYNC_STAGES(2), .DB_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
        bus.addr = {24'h0, a};
        #1;
        chk(tag, bus.rdata, exp);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus.valid = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = {24'h0, a};
        bus.wdata = d;
        step();
        bus.valid = 1'b0;
        bus.we    = 1'b0;
        bus.wdata = '0;
    endtask

    initial begin
        rst_n = 1'b0; gpio_in = '0;
        bus.valid = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        step(); step();
        rst_n = 1'b1;
        step();

        // Reset state
        for (int off = 0; off <= 'h24; off += 4)
            chk_rd($sformatf("reset_rd_%02h", off), 8'(off), 32'h0);
        chk("reset_out", 32'(gpio_out), 32'h0);
        chk("reset_oe", 32'(gpio_oe), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);

        // Direction, data, READ mux
        wr(8'h04, 32'hFF);
        wr(8'h00, 32'hA5);
        chk("out_a5", 32'(gpio_out), 32'hA5);
        chk("oe_ff", 32'(gpio_oe), 32'hFF);
        chk_rd("read_a5", 8'h08, 32'h0000_00A5);
        chk_rd("unmapped_28", 8'h28, 32'h0);
        chk_rd("misaligned_01", 8'h01, 32'h0);

        // Atomic aliases
        wr(8'h00, 32'h0);
        wr(8'h0C, 32'h0F);
        wr(8'h10, 32'h03);
        chk_rd("set_clr", 8'h00, 32'h0C);
        chk("out_0c", 32'(gpio_out), 32'h0C);
        wr(8'h14, 32'hF0);
        chk_rd("tgl", 8'h00, 32'hFC);
        chk("out_fc", 32'(gpio_out), 32'hFC);
        chk_rd("set_reads0", 8'h0C, 32'h0);
        wr(8'h04, 32'h0F);
        chk("out_masked", 32'(gpio_out), 32'h0C);
        bus.valid = 1'b0; bus.we = 1'b1; bus.addr = 32'h0; bus.wdata = 32'h1234;
        step();
        bus.we = 1'b0;
        chk_rd("no_valid_no_write", 8'h00, 32'hFC);

        // Bypass rising edge on pin 0
        wr(8'h04, 32'h0);
        wr(8'h18, 32'h1);
        gpio_in[0] = 1'b1;
        step();
        chk_rd("byp_read_e1", 8'h08, 32'h0);
        step();
        chk_rd("byp_read_e2", 8'h08, 32'h1);
        chk("byp_irq_e2", 32'(irq), 32'h0);
        step();
        chk_rd("byp_stat_e3", 8'h20, 32'h1);
        chk("byp_irq_e3", 32'(irq), 32'h1);
        wr(8'h20, 32'h1);
        chk_rd("w1c_stat", 8'h20, 32'h0);
        chk("w1c_irq", 32'(irq), 32'h0);

        // Edge arriving in the same cycle as its W1C
        gpio_in[0] = 1'b0;
        repeat (4) step();
        chk_rd("fall_not_en", 8'h20, 32'h0);
        gpio_in[0] = 1'b1;
        step(); step();
        wr(8'h20, 32'h1);
        chk_rd("edge_beats_w1c", 8'h20, 32'h1);
        wr(8'h20, 32'h1);
        chk_rd("w1c_again", 8'h20, 32'h0);

        // Falling-edge enable on pin 1
        wr(8'h1C, 32'h2);
        wr(8'h18, 32'h0);
        gpio_in[1] = 1'b1;
        repeat (4) step();
        chk_rd("rise_dis_pin1", 8'h20, 32'h0);
        gpio_in[1] = 1'b0;
        repeat (3) step();
        chk_rd("fall_pin1", 8'h20, 32'h2);
        chk("fall_irq", 32'(irq), 32'h1);
        wr(8'h1C, 32'h0);
        chk_rd("en_clear_keeps", 8'h20, 32'h2);
        wr(8'h20, 32'h2);
        chk("fall_w1c_irq", 32'(irq), 32'h0);

        // Debounce D = 3: short glitch is filtered
        wr(8'h18, 32'h4);
        wr(8'h24, 32'h3);
        chk_rd("deb_cfg", 8'h24, 32'h3);
        bus.addr = 32'h08;
        seen = 1'b0;
        gpio_in[2] = 1'b1;
        step(); step();
        gpio_in[2] = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            seen = seen | bus.rdata[2];
        end
        chk("deb_glitch", 32'(seen), 32'h0);
        chk("deb_glitch_irq", 32'(irq), 32'h0);

        // Held level passes after two agreeing ticks
        gpio_in[2] = 1'b1;
        bus.addr = 32'h08;
        n = 0;
        while (n < 12 && !bus.rdata[2]) begin
            step();
            n++;
        end
        chk("deb_hold_seen", 32'(bus.rdata[2]), 32'h1);
        chk("deb_hold_slow", 32'(n >= 4), 32'h1);
        step(); step();
        chk_rd("deb_stat", 8'h20, 32'h4);
        chk_rd("deb_read", 8'h08, 32'h5);

        // Reset mid-operation
        wr(8'h04, 32'hFFFF_FFFF);
        wr(8'h00, 32'hFFFF_FFFF);
        chk_rd("data_masked", 8'h00, 32'h0000_FFFF);
        chk("out_ffff", 32'(gpio_out), 32'hFFFF);
        chk("pre_rst_irq", 32'(irq), 32'h1);
        rst_n = 1'b0;
        step();
        chk("rst_out", 32'(gpio_out), 32'h0);
        chk("rst_oe", 32'(gpio_oe), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk_rd("rst_data", 8'h00, 32'h0);
        chk_rd("rst_read", 8'h08, 32'h0);
        chk_rd("rst_deb", 8'h24, 32'h0);
        rst_n = 1'b1;
        repeat (6) step();
        chk_rd("post_rst_stat", 8'h20, 32'h0);
        chk("post_rst_irq", 32'(irq), 32'h0);
        chk_rd("post_rst_read", 8'h08, 32'h5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
